// File: rtl/muldiv_seq_if.sv
// Decode-side handshake bundle for the RV32M multi-cycle sequencer.
// master = decode/datapath side, slave = muldiv_seq.
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            kill;
  logic            stall;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (output start, funct3, op_a, op_b, rd_in, kill,
                  input  stall, busy, result_valid, result, rd_out);
  modport slave  (input  start, funct3, op_a, op_b, rd_in, kill,
                  output stall, busy, result_valid, result, rd_out);
endinterface

// File: rtl/muldiv_seq.sv
// RV32M sequencer: radix-2 shift-add multiply / restoring divide on unsigned magnitudes.
// Optional MULDIV_FAST_MUL_EN: MUL-class ops use a one-cycle combinational multiplier.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
    localparam int CW = $clog2(XLEN);

    state_t          state;
    logic [2:0]      f3;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi, lo, dvs;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            result_valid, busy;

    logic idle_like, accept;
    assign idle_like = (state == IDLE) || (state == DONE);
    assign accept    = bus.start & idle_like & ~bus.kill;
    assign bus.stall = rst & (accept | (state == ITER) | (state == FIX));

    // Operand signedness: a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
    logic sa, sb, a_neg, b_neg, is_div, dz, ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;
    assign sa     = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b010) |
                    (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110);
    assign sb     = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110);
    assign a_neg  = sa & bus.op_a[XLEN-1];
    assign b_neg  = sb & bus.op_b[XLEN-1];
    assign a_mag  = a_neg ? -bus.op_a : bus.op_a;
    assign b_mag  = b_neg ? -bus.op_b : bus.op_b;
    assign is_div = bus.funct3[2];
    assign dz     = (bus.op_b == '0);
    assign ovf    = sb & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op_b);

    always_comb begin
        spec_res = '0;
        if (dz) spec_res = bus.funct3[1] ? bus.op_a : '1;
        else    spec_res = bus.funct3[1] ? '0 : bus.op_a;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fmag, fprod;
    logic [XLEN-1:0]   fres;
    assign fmag  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign fprod = (a_neg ^ b_neg) ? -fmag : fmag;
    assign fres  = (bus.funct3[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`endif

    // One engine step: multiply adds dvs into hi when lo[0] set, then shifts right;
    // divide shifts {hi,lo} left and subtracts dvs from the partial remainder.
    logic [XLEN:0] msum, rtmp, diff;
    assign msum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    assign rtmp = {hi, lo[XLEN-1]};
    assign diff = rtmp - {1'b0, dvs};

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   q_s, r_s, fix_res;
    assign prod_s = neg_q ? -{hi, lo} : {hi, lo};
    assign q_s    = neg_q ? -lo : lo;
    assign r_s    = neg_r ? -hi : hi;

    always_comb begin
        fix_res = '0;
        if (f3[2])                fix_res = f3[1] ? r_s : q_s;
        else if (f3[1:0] == 2'b00) fix_res = prod_s[XLEN-1:0];
        else                      fix_res = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            f3           <= '0;
            cnt          <= '0;
            hi           <= '0;
            lo           <= '0;
            dvs          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            result       <= '0;
            rd_out       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (accept) begin
                        f3     <= bus.funct3;
                        rd_out <= bus.rd_in;
                        cnt    <= '0;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (is_div && (dz || ovf)) begin
                            result       <= spec_res;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div) begin
                            result       <= fres;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
`endif
                        else begin
                            state <= ITER;
                            busy  <= 1'b1;
                            hi    <= '0;
                            lo    <= a_mag;
                            dvs   <= b_mag;
                        end
                    end
                end
                ITER: begin
                    if (bus.kill) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (f3[2]) begin
                            if (!diff[XLEN]) begin
                                hi <= diff[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b1};
                            end else begin
                                hi <= rtmp[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            {hi, lo} <= {msum, lo[XLEN-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(XLEN-1)) state <= FIX;
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    if (bus.kill) begin
                        state <= IDLE;
                    end else begin
                        result       <= fix_res;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy;
    assign bus.result_valid = result_valid;
    assign bus.result       = result;
    assign bus.rd_out       = rd_out;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected {result, rd, cycle},
// a negedge monitor pops and compares on every result_valid.
module tb_muldiv_seq;
    localparam int XLEN = 32;
    localparam int DLAT = XLEN + 2;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MLAT = 1;
`else
    localparam int MLAT = XLEN + 2;
`endif

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    muldiv_seq_if #(.XLEN(XLEN)) bus();

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid actual result=%h required no strobe", bus.result);
            end else begin
                e = sb.pop_front();
                chk("result", bus.result, e.res);
                chk("rd_out", 32'(bus.rd_out), 32'(e.rd));
                chk("valid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Drive one start pulse at a negedge; returns at the following negedge (cycle 1).
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat,
                         input bit push);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
        if (push) sb.push_back('{exp, rd, cyc + lat});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
        issue(f, a, b, rd, exp, lat, 1'b1);
        drain();
        @(negedge clk);
    endtask

    initial begin
        int n;
        int stall_cnt;
        rst = 1'b0;
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd7; bus.op_b = 32'd3;
        bus.rd_in = 5'd9; bus.kill = 1'b0;

        // Reset held with start asserted
        #22;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_stall", 32'(bus.stall), 32'd0);

        // MUL 7 * -6 with stall-window count
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd7; bus.op_b = 32'hFFFF_FFFA;
        bus.rd_in = 5'd5;
        sb.push_back('{32'hFFFF_FFD6, 5'd5, cyc + MLAT});
        #1;
        stall_cnt = bus.stall ? 1 : 0;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.result_valid !== 1'b1 && n < 100) begin
            if (bus.stall) stall_cnt++;
            @(negedge clk);
            n++;
        end
        chk("mul_done_stall", 32'(bus.stall), 32'd0);
        chk("mul_stall_cycles", 32'(stall_cnt), 32'(MLAT));
        drain();
        @(negedge clk);

        run(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, MLAT);
        run(3'b010, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'hC000_0000, MLAT);
        run(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, MLAT);
        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, MLAT);
        run(3'b000, 32'h1234_5678, 32'h0000_0010, 5'd11, 32'h2345_6780, MLAT);
        run(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFD, DLAT);
        run(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFF, DLAT);
        run(3'b100, 32'd7,         32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, DLAT);
        run(3'b110, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'd1,         DLAT);
        run(3'b111, 32'd100,       32'd7,         5'd16, 32'd2,         DLAT);
        run(3'b101, 32'd100,       32'd0,         5'd17, 32'hFFFF_FFFF, 1);
        run(3'b111, 32'd5,         32'd0,         5'd18, 32'd5,         1);
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         1);
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1);

        // Back-to-back: second start lands in the DONE cycle
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, DLAT, 1'b1);
        n = 0;
        while (bus.result_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd100; bus.op_b = 32'd7;
        bus.rd_in = 5'd4;
        sb.push_back('{32'd14, 5'd4, cyc + DLAT});
        #1;
        chk("b2b_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        @(negedge clk);

        // start pulsed during ITER is ignored
        issue(3'b101, 32'd1000, 32'd10, 5'd21, 32'd100, DLAT, 1'b1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd9; bus.op_b = 32'd0;
        bus.rd_in = 5'd22;
        #1;
        chk("iter_busy", 32'(bus.busy), 32'd1);
        chk("iter_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // kill in ITER cycle 10
        issue(3'b101, 32'd1000, 32'd3, 5'd23, 32'd0, DLAT, 1'b0);
        repeat (9) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        chk("kill_busy", 32'(bus.busy), 32'd0);
        chk("kill_stall", 32'(bus.stall), 32'd0);
        chk("kill_result_kept", bus.result, 32'd100);
        repeat (40) @(negedge clk);
        chk("kill_result_after", bus.result, 32'd100);

        // reset pulse in ITER cycle 10
        issue(3'b101, 32'd1000, 32'd3, 5'd24, 32'd0, DLAT, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstpulse_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("rstpulse_result", bus.result, 32'd0);
        repeat (40) @(negedge clk);
        chk("rstpulse_idle", 32'(bus.busy), 32'd0);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual time=%0t required finish", $time);
        $fatal(1);
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M extension. It sits beside the single-cycle Datapath ALU.
- Accepts one MUL/DIV-class operation from decode and stalls the datapath while it runs.
- Runs the operation on an internal radix-2 shift-add / shift-subtract engine, then presents a one-cycle result for register writeback.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- start  input  1  decode has a valid M-extension instruction this cycle.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value.
- rd_in  input  5  destination register index.
- kill  input  1  pipeline flush; aborts the current operation.
- stall  output  1  freeze PC and fetch/decode registers.
- busy  output  1  operation in progress (registered).
- result_valid  output  1  one-cycle writeback strobe.
- result  output  XLEN  value for rd.
- rd_out  output  5  latched rd_in.

Behaviour:
- States: IDLE, ITER, FIX, DONE. Reset (rst=0, asynchronous) forces IDLE and clears everything: busy=0, result_valid=0, result=0, rd_out=0, counter=0, internal accumulators=0.
- Acceptance: start is accepted only in IDLE or DONE, and only when kill=0. On acceptance the block latches funct3, rd_in, |op_a| and |op_b| (signed per funct3), and the result-sign flags.
- start in ITER or FIX is ignored; the datapath is already stalled.
- stall is combinational: (start & (IDLE|DONE) & ~kill) | ITER | FIX. It is 0 in DONE so that writeback and the PC advance occur.
- Normal timing (start high in cycle 0):
  - cycles 1..XLEN: ITER, counter 0..XLEN-1, one shift/add or shift/subtract step per cycle.
  - cycle XLEN+1: FIX applies two's-complement negation per sign flags and selects the high/low product, or the quotient/remainder.
  - cycle XLEN+2: DONE with result_valid=1, result and rd_out stable.
  - Total latency with XLEN=32: result_valid in cycle 34.
- DONE lasts exactly one cycle. It then goes to IDLE, or to ITER if a new start is accepted in DONE (back-to-back). result holds its value until the next FIX or special-case load.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - The multiplier forms a 2*XLEN product. MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Division special cases bypass ITER and go straight to DONE in cycle 1:
  - Divide by zero (op_b=0): DIV/DIVU result = all ones; REM/REMU result = op_a.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- Remainder sign follows the dividend; quotient sign = sign(a) XOR sign(b). A zero quotient or remainder is never negated to a non-zero value.
- kill in ITER/FIX/DONE: next state IDLE, result_valid suppressed, result unchanged. kill has priority over start.
- Reset asserted mid-operation: immediate IDLE; no result_valid after release.
- busy=1 in ITER and FIX only.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MUL-class funct3 (0xx) uses a single-cycle combinational 2*XLEN multiplier. State goes IDLE→DONE with result registered at acceptance, so result_valid is in cycle 1 and stall is high only in cycle 0 (via start). DIV-class timing is unchanged.
- Undefined: all eight ops use the iterative engine with XLEN+2 latency. No hardware multiplier is inferred.

Test Plan:
- Reset: hold rst=0 with start=1 → stall=0, busy=0, result_valid=0, result=0, rd_out=0; release rst → still IDLE.
- MUL: op_a=7, op_b=0xFFFFFFFA (−6), rd_in=5 → result_valid in cycle 34 (cycle 1 with MULDIV_FAST_MUL_EN), result=0xFFFFFFD6, rd_out=5; stall high cycles 0–33 (cycle 0 only with macro).
- MULH, MULHSU, MULHU with op_a=op_b=0x80000000 → results 0x40000000, 0xC0000000, 0x40000000 respectively.
- DIV/REM: op_a=−7, op_b=2 → DIV=0xFFFFFFFD, REM=0xFFFFFFFF; DIVU 100/0 → 0xFFFFFFFF in cycle 1; REM 0x80000000 by −1 → 0 in cycle 1.
- Back-to-back: new start in the DONE cycle → accepted, second result_valid exactly XLEN+2 cycles later; start pulsed during ITER → ignored, no extra result.
- Abort: kill in ITER cycle 10 → IDLE next cycle, no result_valid, result retains prior value. Repeat with rst=0 pulsed mid-ITER → same outcome.
